// File: rtl/qu_common.sv
// Shared types for the execute/writeback queue slice: reservation-station cell and
// the result entry held by the execute result buffer.
package qu_common;

  localparam int EXEC_RESULT_BUF_DEPTH = 4;

  typedef enum logic [2:0] {
    OP_NONE   = 3'd0,
    OP_ALU    = 3'd1,
    OP_MUL    = 3'd2,
    OP_BRANCH = 3'd3,
    OP_LOAD   = 3'd4,
    OP_STORE  = 3'd5,
    OP_JUMP   = 3'd6,
    OP_CSR    = 3'd7
  } optype_t;

  typedef struct packed {
    logic        busy;
    optype_t     optype;
    logic [3:0]  rob_tag;
    logic [4:0]  rd;
    logic [11:0] imm;
  } res_st_cell_t;

  typedef struct packed {
    logic [31:0]  value;
    logic         comp;
    res_st_cell_t op;
  } wb_entry_t;

endpackage

// File: rtl/exec_result_buffer.sv
// In-order result queue between execute and the CDB/writeback. Decouples execute from
// CDB arbitration stalls; flush drops all speculative entries.
module exec_result_buffer
  import qu_common::*;
#(
  parameter  int DEPTH = EXEC_RESULT_BUF_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_value,
  input  logic             in_comp,
  input  res_st_cell_t     in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_value,
  output logic             out_comp,
  output res_st_cell_t     out_op,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  wb_entry_t        head;

  // Occupancy, not pointer equality, distinguishes full from empty.
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;

  // in_ready depends only on registered state, so a pop in the same cycle cannot open a slot.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage carries no reset; validity comes from count, and an unreset array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{value: in_value, comp: in_comp, op: in_op};
  end

  // NOTE: every output gets a default first so this block cannot infer a latch.
  always_comb begin
    head      = '0;
    out_value = '0;
    out_comp  = 1'b0;
    out_op    = '0;
    if (!empty) begin
      head      = mem[rd_ptr];
      out_value = head.value;
      out_comp  = head.comp;
      out_op    = head.op;
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && full));

  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    !(pop && empty));

  a_count_range: assert property (@(posedge clk) disable iff (rst)
    count <= FULL_COUNT);

  // Execute must hold a refused result until it is taken.
  a_in_hold: assert property (@(posedge clk) disable iff (rst)
    (in_valid && !in_ready && !flush) |=>
      (in_valid && $stable(in_value) && $stable(in_comp) && $stable(in_op)));

endmodule

// File: tb/tb_exec_result_buffer.sv
// Directed table plus hand sequences and a scoreboarded random phase for exec_result_buffer.
module tb_exec_result_buffer;
  import qu_common::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_value;
  logic         in_comp;
  res_st_cell_t in_op;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_value;
  logic         out_comp;
  res_st_cell_t out_op;
  logic [2:0]   count;

  int errors = 0;
  int checks = 0;

  exec_result_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_comp   (in_comp),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_comp  (out_comp),
    .out_op    (out_op),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        in_valid;
    logic [31:0] in_value;
    logic        out_ready;
    int          exp_count;
    logic        exp_valid;
    logic        exp_ready;
    logic [31:0] exp_value;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];

  // Op cell and comp bit are derived from the value so one number describes a whole entry.
  function automatic res_st_cell_t mk_op(input logic [31:0] v);
    res_st_cell_t op;
    op.busy    = 1'b1;
    op.optype  = optype_t'(v[2:0]);
    op.rob_tag = v[7:4];
    op.rd      = v[12:8];
    op.imm     = v[31:20];
    return op;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic iv, input logic [31:0] v, input logic orr);
    flush     = f;
    in_valid  = iv;
    in_value  = v;
    in_comp   = v[0];
    in_op     = mk_op(v);
    out_ready = orr;
  endtask

  task automatic check_outputs(input string tag, input int ec, input logic ev,
                               input logic er, input logic [31:0] eval);
    check({tag, " count"}, 64'(count), 64'(ec));
    check({tag, " out_valid"}, 64'(out_valid), 64'(ev));
    check({tag, " in_ready"}, 64'(in_ready), 64'(er));
    check({tag, " out_value"}, 64'(out_value), 64'(eval));
    check({tag, " out_comp"}, 64'(out_comp), 64'(ev ? eval[0] : 1'b0));
    check({tag, " out_op"}, 64'(out_op), 64'(ev ? mk_op(eval) : res_st_cell_t'('0)));
  endtask

  function automatic void add(input logic f, input logic iv, input logic [31:0] v, input logic orr,
                              input int ec, input logic ev, input logic er, input logic [31:0] eval);
    vec_t t;
    t.flush = f; t.in_valid = iv; t.in_value = v; t.out_ready = orr;
    t.exp_count = ec; t.exp_valid = ev; t.exp_ready = er; t.exp_value = eval;
    vecs.push_back(t);
  endfunction

  initial begin
    // Fill, refused fifth push, drain with wrap, simultaneous push/pop, empty pop, flush.
    add(0, 1, 32'h1,   0, 1, 1, 1, 32'h1);
    add(0, 1, 32'h2,   0, 2, 1, 1, 32'h1);
    add(0, 1, 32'h3,   0, 3, 1, 1, 32'h1);
    add(0, 1, 32'h4,   0, 4, 1, 0, 32'h1);
    add(0, 1, 32'h5,   0, 4, 1, 0, 32'h1);
    add(0, 1, 32'h5,   1, 3, 1, 1, 32'h2);
    add(0, 1, 32'h5,   1, 3, 1, 1, 32'h3);
    add(0, 1, 32'h6,   1, 3, 1, 1, 32'h4);
    add(0, 0, 32'h0,   1, 2, 1, 1, 32'h5);
    add(0, 0, 32'h0,   1, 1, 1, 1, 32'h6);
    add(0, 0, 32'h0,   1, 0, 0, 1, 32'h0);
    add(0, 1, 32'h7,   0, 1, 1, 1, 32'h7);
    add(0, 1, 32'h8,   0, 2, 1, 1, 32'h7);
    add(0, 1, 32'h9,   1, 2, 1, 1, 32'h8);
    add(0, 0, 32'h0,   1, 1, 1, 1, 32'h9);
    add(0, 0, 32'h0,   1, 0, 0, 1, 32'h0);
    add(0, 0, 32'h0,   1, 0, 0, 1, 32'h0);
    add(0, 1, 32'h100, 0, 1, 1, 1, 32'h100);
    add(0, 1, 32'h101, 0, 2, 1, 1, 32'h100);
    add(0, 1, 32'h102, 0, 3, 1, 1, 32'h100);
    add(1, 1, 32'h103, 1, 0, 0, 1, 32'h0);
    add(0, 0, 32'h0,   0, 0, 0, 1, 32'h0);
    add(0, 1, 32'h200, 0, 1, 1, 1, 32'h200);
    add(0, 0, 32'h0,   1, 0, 0, 1, 32'h0);

    // Reset held with a result offered: nothing may enter.
    rst = 1'b1;
    drive(0, 1, 32'hDEADBEEF, 0);
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 0, 0, 1, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 32'hDEADBEEF, 0);
    #1;
    check("no bypass out_valid", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    check_outputs("first push", 1, 1, 1, 32'hDEADBEEF);

    @(negedge clk);
    drive(0, 0, 32'h0, 1);
    @(posedge clk);
    #1;
    check_outputs("first pop", 0, 0, 1, 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].flush, vecs[i].in_valid, vecs[i].in_value, vecs[i].out_ready);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_valid,
                    vecs[i].exp_ready, vecs[i].exp_value);
    end

    // Random push/pop against a scoreboard queue; pushes only offered when the model has room.
    for (int cyc = 0; cyc < 50; cyc++) begin
      logic        iv;
      logic        orr;
      logic [31:0] v;
      @(negedge clk);
      check($sformatf("rnd%0d count", cyc), 64'(count), 64'(sb.size()));
      check($sformatf("rnd%0d out_valid", cyc), 64'(out_valid), 64'(sb.size() != 0));
      if (sb.size() != 0)
        check($sformatf("rnd%0d out_value", cyc), 64'(out_value), 64'(sb[0]));
      iv  = ($urandom_range(0, 1) == 1) && (sb.size() < 4);
      orr = ($urandom_range(0, 1) == 1);
      v   = $urandom;
      drive(0, iv, v, orr);
      @(posedge clk);
      if (orr && sb.size() != 0) void'(sb.pop_front());
      if (iv) sb.push_back(v);
    end

    @(negedge clk);
    drive(1, 0, 32'h0, 0);
    @(posedge clk);
    #1;
    check_outputs("post-random flush", 0, 0, 1, 32'h0);

    // Asynchronous reset mid-cycle with two entries held.
    @(negedge clk);
    drive(0, 1, 32'hA1, 0);
    @(negedge clk);
    drive(0, 1, 32'hA2, 0);
    @(posedge clk);
    #1;
    check_outputs("pre-rst", 2, 1, 1, 32'hA1);
    drive(0, 0, 32'h0, 0);
    #2;
    rst = 1'b1;
    #1;
    check_outputs("async rst", 0, 0, 1, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive(0, 1, 32'h5A5A1234, 0);
    @(posedge clk);
    #1;
    check_outputs("post-rst push", 1, 1, 1, 32'h5A5A1234);
    @(negedge clk);
    drive(0, 0, 32'h0, 1);
    @(posedge clk);
    #1;
    check_outputs("post-rst pop", 0, 0, 1, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
